ysyx_23060236_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_23060236_hazard_ctrl

Overview:
- Scoreboard-based issue controller for the in-order RV32E pipeline, placed between decode and execute.
- Tracks outstanding register writes to x1..x15 and decides whether the decoded instruction may issue.
- Selects bypass from the writeback value when a source's last pending write retires in the same cycle.
- Releases scoreboard entries on writeback or on squash after a mispredicted jump.

Parameters:
- NREG, 16, number of architectural registers tracked; x0 is never tracked.
- CNT_W, 2, width of the per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  decoded instruction present
- issue_ready  out  1  instruction may issue this cycle
- rs1  in  4  source register 1
- rs2  in  4  source register 2
- need_rs1  in  1  instruction reads rs1
- need_rs2  in  1  instruction reads rs2
- rd  in  4  destination register
- reg_wen  in  1  instruction writes rd
- wb_valid  in  1  writeback of one instruction this cycle
- wb_rd  in  4  writeback destination
- wb_wen  in  1  writeback writes a register
- kill_valid  in  1  one issued, uncommitted instruction is squashed
- kill_rd  in  4  squashed instruction's destination
- kill_wen  in  1  squashed instruction had reg_wen
- fwd_rs1  out  1  take rs1 from the writeback value
- fwd_rs2  out  1  take rs2 from the writeback value
- busy_mask  out  16  bit i set when cnt[i] != 0
- sb_err  out  1  sticky flag: decrement attempted at zero

Behaviour:
- State: cnt[1..15], each CNT_W bits; cnt[0] is hard-wired to 0. Reset drives all cnt to 0, busy_mask to 0, sb_err to 0. Reset is honoured mid-operation on any cycle.
- wb_hit(r) = wb_valid & wb_wen & wb_rd==r & r!=0.
- src_block(r, need) = need & r!=0 & cnt[r]!=0 & ~(cnt[r]==1 & wb_hit(r)).
- fwd_rsN = need_rsN & rsN!=0 & cnt[rsN]==1 & wb_hit(rsN). This is combinational, same cycle.
- rd_full = reg_wen & rd!=0 & cnt[rd]==max.
- issue_ready = ~src_block(rs1) & ~src_block(rs2) & ~rd_full & ~kill_valid. Issue is blocked during a squash cycle.
- issue_ready is independent of issue_valid, so there is no combinational loop.
- Issue fires when issue_valid & issue_ready.
- Per-cycle update for each r in 1..15: cnt[r] <= cnt[r] + inc - dec_wb - dec_kill.
  - inc = fire & reg_wen & rd==r.
  - dec_wb = wb_hit(r).
  - dec_kill = kill_valid & kill_wen & kill_rd==r.
- Simultaneous events on one register:
  - Issue + wb: net 0.
  - wb + kill: net -2.
  - Issue + wb + kill: net -1.
- Arithmetic is CNT_W+1 bits signed internally.
- If the result is < 0: clamp cnt to 0 and set sb_err (sticky until reset).
- Saturation cannot occur, because issue is blocked at max.
- Latency: a scoreboard set becomes visible the cycle after fire. A clear is visible the same cycle via the wb_hit term.
- rs1==rs2: both checks apply; no special case.

Optional Feature:
- Macro YSYX_23060236_HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cycles (32) and perf_stall_events (32).
  - perf_stall_cycles counts cycles with issue_valid & ~issue_ready.
  - perf_stall_events counts rising edges of that condition, using a registered previous-stall bit.
  - Both counters are reset to 0 and wrap at 2^32.
- When undefined, neither the ports nor the registers exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NREG and CNT_W defaults
  - the register-index width constant (4)
  - the localparam X0 = 0
- Natural sub-module: ysyx_23060236_sb_cnt, a single-register pending counter with inc/dec_wb/dec_kill inputs, clamp, and an err output. It is instantiated 15 times via generate.

Test Plan:
- Reset: after reset release with all inputs idle -> busy_mask=16'h0000, issue_ready=1, sb_err=0.
- Back-to-back RAW:
  - Issue rd=5 (reg_wen=1); next cycle present rs1=5, need_rs1=1 -> issue_ready=0, busy_mask[5]=1.
  - When wb_rd=5 with wb_valid=1 -> issue_ready=1 and fwd_rs1=1 in that cycle; next cycle busy_mask[5]=0.
- Saturation: issue three writes to rd=3 with no wb -> cnt[3]=3. A fourth issue with rd=3 -> issue_ready=0 until one wb to x3.
- Simultaneous: cnt[7]=1; in the same cycle issue rd=7 and wb rd=7 -> cnt[7] stays 1 and busy_mask[7]=1.
- Squash: cnt[9]=1; kill_valid=1, kill_rd=9, kill_wen=1 -> issue_ready=0 that cycle, then cnt[9]=0. A second kill on x9 -> sb_err=1, cnt[9]=0.
- x0: issue rd=0 and read rs1=0 repeatedly -> never stalls, busy_mask[0] always 0. With PERF_EN, stall counters stay 0.

Source files
------------

// File: rtl/ysyx_23060236_hazard_ctrl_pkg.sv
// ysyx_23060236_hazard_ctrl_pkg: shared constants for the RV32E issue scoreboard
//   NREG_DEFAULT  - architectural registers tracked (x0 never tracked)
//   CNT_W_DEFAULT - width of each per-register pending-write counter
//   REG_W         - register index width
//   X0            - index of the hard-wired zero register
package ysyx_23060236_hazard_ctrl_pkg;
    localparam int NREG_DEFAULT  = 16;
    localparam int CNT_W_DEFAULT = 2;
    localparam int REG_W         = 4;
    localparam logic [REG_W-1:0] X0 = '0;
endpackage

// File: rtl/ysyx_23060236_sb_cnt.sv
// ysyx_23060236_sb_cnt: pending-write counter for one architectural register
//   clock, reset           - clock, asynchronous active-low reset
//   inc                    - an instruction writing this register issues
//   dec_wb, dec_kill       - a pending write retires / is squashed
//   cnt                    - outstanding writes
//   err                    - sticky: a decrement was attempted below zero
module ysyx_23060236_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_kill,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;
    logic [CNT_W:0]   sum;
    // One extra bit holds the sign; the range is -2..max, so the top bit marks underflow.
    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc) - (CNT_W+1)'(dec_wb) - (CNT_W+1)'(dec_kill);
        cnt_d = sum[CNT_W] ? '0 : sum[CNT_W-1:0];
        err_d = err_q | sum[CNT_W];
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign cnt = cnt_q;
    assign err = err_q;
endmodule

// File: rtl/ysyx_23060236_hazard_ctrl.sv
// ysyx_23060236_hazard_ctrl: scoreboard issue controller between decode and execute
//   clock, reset                        - clock, asynchronous active-low reset
//   issue_valid/issue_ready             - decoded instruction handshake
//   rs1, rs2, need_rs1, need_rs2        - sources read by the decoded instruction
//   rd, reg_wen                         - its destination
//   wb_valid, wb_rd, wb_wen             - retiring write
//   kill_valid, kill_rd, kill_wen       - squashed in-flight instruction
//   fwd_rs1, fwd_rs2                    - take source from the writeback value
//   busy_mask                           - registers with pending writes
//   sb_err                              - sticky counter underflow flag
//   perf_stall_cycles/events            - only with YSYX_23060236_HAZARD_PERF_EN defined
module ysyx_23060236_hazard_ctrl
    import ysyx_23060236_hazard_ctrl_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             need_rs1,
    input  logic             need_rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             reg_wen,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    input  logic             kill_valid,
    input  logic [REG_W-1:0] kill_rd,
    input  logic             kill_wen,
    output logic             fwd_rs1,
    output logic             fwd_rs2,
    output logic [NREG-1:0]  busy_mask,
    output logic             sb_err
`ifdef YSYX_23060236_HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_stall_events
`endif
);
    logic [NREG-1:0] wb_hit, kill_hit, inc, cnt_one, cnt_full, err;
    logic            fire, blk1, blk2, rd_full;
    assign wb_hit[0]    = 1'b0;
    assign kill_hit[0]  = 1'b0;
    assign inc[0]       = 1'b0;
    assign cnt_one[0]   = 1'b0;
    assign cnt_full[0]  = 1'b0;
    assign err[0]       = 1'b0;
    assign busy_mask[0] = 1'b0;
    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        assign wb_hit[i]   = wb_valid & wb_wen & (wb_rd == REG_W'(i));
        assign kill_hit[i] = kill_valid & kill_wen & (kill_rd == REG_W'(i));
        assign inc[i]      = fire & reg_wen & (rd == REG_W'(i));
        ysyx_23060236_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (inc[i]),
            .dec_wb   (wb_hit[i]),
            .dec_kill (kill_hit[i]),
            .cnt      (cnt),
            .err      (err[i])
        );
        assign busy_mask[i] = |cnt;
        assign cnt_one[i]   = cnt == CNT_W'(1);
        assign cnt_full[i]  = &cnt;
    end
    // A source whose last pending write retires this cycle is not a hazard: it is bypassed.
    always_comb begin
        fwd_rs1     = need_rs1 & (rs1 != X0) & cnt_one[rs1] & wb_hit[rs1];
        fwd_rs2     = need_rs2 & (rs2 != X0) & cnt_one[rs2] & wb_hit[rs2];
        blk1        = need_rs1 & (rs1 != X0) & busy_mask[rs1] & ~fwd_rs1;
        blk2        = need_rs2 & (rs2 != X0) & busy_mask[rs2] & ~fwd_rs2;
        rd_full     = reg_wen & (rd != X0) & cnt_full[rd];
        issue_ready = ~blk1 & ~blk2 & ~rd_full & ~kill_valid;
        fire        = issue_valid & issue_ready;
    end
    assign sb_err = |err;
`ifdef YSYX_23060236_HAZARD_PERF_EN
    logic        stall, stall_prev_d, stall_prev_q;
    logic [31:0] cycles_d, cycles_q, events_d, events_q;
    always_comb begin
        stall        = issue_valid & ~issue_ready;
        stall_prev_d = stall;
        cycles_d     = cycles_q + 32'(stall);
        events_d     = events_q + 32'(stall & ~stall_prev_q);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_prev_q <= 1'b0;
            cycles_q     <= '0;
            events_q     <= '0;
        end else begin
            stall_prev_q <= stall_prev_d;
            cycles_q     <= cycles_d;
            events_q     <= events_d;
        end
    end
    assign perf_stall_cycles = cycles_q;
    assign perf_stall_events = events_q;
`endif
endmodule

// File: tb/tb_ysyx_23060236_hazard_ctrl.sv
// tb_ysyx_23060236_hazard_ctrl: directed and randomized checks of the issue scoreboard
module tb_ysyx_23060236_hazard_ctrl;
    logic        clock = 1'b0, reset = 1'b0;
    logic        issue_valid, issue_ready, need_rs1, need_rs2, reg_wen;
    logic        wb_valid, wb_wen, kill_valid, kill_wen, fwd_rs1, fwd_rs2, sb_err;
    logic [3:0]  rs1, rs2, rd, wb_rd, kill_rd;
    logic [15:0] busy_mask;
    int checks = 0, failures = 0;
    int cnt_m [16];
    bit err_m;
`ifdef YSYX_23060236_HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_stall_events;
    int unsigned cyc_m, ev_m;
    bit prev_m;
`endif

    ysyx_23060236_hazard_ctrl dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .need_rs1(need_rs1), .need_rs2(need_rs2), .rd(rd), .reg_wen(reg_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_wen(kill_wen),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .busy_mask(busy_mask), .sb_err(sb_err)
`ifdef YSYX_23060236_HAZARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_stall_events(perf_stall_events)
`endif
    );

    always #5 clock = ~clock;

    function automatic bit m_hit(input int r);
        return wb_valid && wb_wen && int'(wb_rd) == r && r != 0;
    endfunction
    function automatic bit m_fwd(input int r, input bit need);
        return need && r != 0 && cnt_m[r] == 1 && m_hit(r);
    endfunction
    function automatic bit m_block(input int r, input bit need);
        return need && r != 0 && cnt_m[r] != 0 && !m_fwd(r, need);
    endfunction
    function automatic bit m_ready();
        return !m_block(int'(rs1), need_rs1) && !m_block(int'(rs2), need_rs2)
            && !(reg_wen && rd != 0 && cnt_m[rd] == 3) && !kill_valid;
    endfunction
    function automatic logic [15:0] m_busy();
        logic [15:0] b = '0;
        for (int r = 1; r < 16; r++) b[r] = cnt_m[r] != 0;
        return b;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 16; r++) cnt_m[r] = 0;
            err_m = 0;
`ifdef YSYX_23060236_HAZARD_PERF_EN
            cyc_m = 0; ev_m = 0; prev_m = 0;
`endif
        end else begin
            bit fire, stall;
            fire  = issue_valid && m_ready();
            stall = issue_valid && !m_ready();
            for (int r = 1; r < 16; r++) begin
                int n;
                n = cnt_m[r] + int'(fire && reg_wen && int'(rd) == r) - int'(m_hit(r))
                  - int'(kill_valid && kill_wen && int'(kill_rd) == r);
                if (n < 0) begin n = 0; err_m = 1; end
                cnt_m[r] = n;
            end
`ifdef YSYX_23060236_HAZARD_PERF_EN
            cyc_m += int'(stall);
            if (stall && !prev_m) ev_m++;
            prev_m = stall;
`else
            if (stall) ;
`endif
        end
    end

    task automatic idle();
        issue_valid = 0; need_rs1 = 0; need_rs2 = 0; reg_wen = 0; rs1 = 0; rs2 = 0; rd = 0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0; kill_valid = 0; kill_wen = 0; kill_rd = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock); idle(); reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
    endtask

    task automatic issue(input logic [3:0] d, input logic [3:0] s1, input bit n1);
        issue_valid = 1; rd = d; reg_wen = 1; rs1 = s1; need_rs1 = n1;
    endtask

    task automatic wb(input logic [3:0] d);
        wb_valid = 1; wb_wen = 1; wb_rd = d;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock); #1;
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0000", busy_mask); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
        checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_raw();
        apply_reset();
        @(negedge clock); idle(); issue(5, 0, 0); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready got=%b exp=1", issue_ready); end
        @(negedge clock); idle(); issue_valid = 1; rs1 = 5; need_rs1 = 1; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
        checks++; if (busy_mask[5] !== 1'b1) begin failures++; $display("FAIL raw_busy5 got=%b exp=1", busy_mask[5]); end
        @(negedge clock); wb(5); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_bypass_ready got=%b exp=1", issue_ready); end
        checks++; if (fwd_rs1 !== 1'b1) begin failures++; $display("FAIL raw_fwd_rs1 got=%b exp=1", fwd_rs1); end
        @(negedge clock); idle(); #1;
        checks++; if (busy_mask[5] !== 1'b0) begin failures++; $display("FAIL raw_clear5 got=%b exp=0", busy_mask[5]); end
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (3) begin @(negedge clock); idle(); issue(3, 0, 0); end
        @(negedge clock); idle(); issue(3, 0, 0); #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sat_full got=%b exp=0", issue_ready); end
        @(negedge clock); idle(); wb(3);
        @(negedge clock); idle(); issue(3, 0, 0); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sat_after_wb got=%b exp=1", issue_ready); end
        repeat (3) begin @(negedge clock); idle(); wb(3); end
        @(negedge clock); idle(); #1;
        checks++; if (busy_mask !== 16'h0) begin failures++; $display("FAIL sat_drain got=%h exp=0000", busy_mask); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        @(negedge clock); idle(); issue(7, 0, 0);
        @(negedge clock); idle(); issue(7, 0, 0); wb(7); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL simul_ready got=%b exp=1", issue_ready); end
        @(negedge clock); idle(); #1;
        checks++; if (busy_mask !== 16'h0080) begin failures++; $display("FAIL simul_busy got=%h exp=0080", busy_mask); end
        @(negedge clock); idle(); wb(7);
        @(negedge clock); idle(); #1;
        checks++; if (busy_mask !== 16'h0 || sb_err !== 1'b0) begin failures++; $display("FAIL simul_clear got=%h/%b exp=0000/0", busy_mask, sb_err); end
    endtask

    task automatic test_squash();
        apply_reset();
        @(negedge clock); idle(); issue(9, 0, 0);
        @(negedge clock); idle(); issue(1, 0, 0); kill_valid = 1; kill_wen = 1; kill_rd = 9; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL squash_block got=%b exp=0", issue_ready); end
        @(negedge clock); idle(); #1;
        checks++; if (busy_mask !== 16'h0 || sb_err !== 1'b0) begin failures++; $display("FAIL squash_clear got=%h/%b exp=0000/0", busy_mask, sb_err); end
        kill_valid = 1; kill_wen = 1; kill_rd = 9;
        @(negedge clock); idle(); #1;
        checks++; if (sb_err !== 1'b1 || busy_mask !== 16'h0) begin failures++; $display("FAIL squash_underflow got=%b/%h exp=1/0000", sb_err, busy_mask); end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL squash_sticky got=%b exp=1", sb_err); end
    endtask

    task automatic test_x0();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); idle(); issue(0, 0, 1); need_rs2 = 1; #1;
            checks++; if (issue_ready !== 1'b1 || busy_mask[0] !== 1'b0) begin failures++; $display("FAIL x0_cycle%0d got=%b/%b exp=1/0", i, issue_ready, busy_mask[0]); end
        end
`ifdef YSYX_23060236_HAZARD_PERF_EN
        checks++; if (perf_stall_cycles !== 0 || perf_stall_events !== 0) begin failures++; $display("FAIL x0_perf got=%0d/%0d exp=0/0", perf_stall_cycles, perf_stall_events); end
`endif
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (i % 150 == 149) begin
                reset = 0; #1;
                checks++; if (busy_mask !== 16'h0 || sb_err !== 1'b0) begin failures++; $display("FAIL rand_midreset got=%h/%b exp=0000/0", busy_mask, sb_err); end
                @(negedge clock); reset = 1;
            end
            issue_valid = $urandom_range(0, 3) != 0;
            rs1 = rreg(); rs2 = rreg(); rd = rreg();
            need_rs1 = $urandom_range(0, 1) == 1; need_rs2 = $urandom_range(0, 1) == 1; reg_wen = $urandom_range(0, 3) != 0;
            wb_valid = $urandom_range(0, 9) < 4; wb_wen = $urandom_range(0, 4) != 0; wb_rd = rreg();
            kill_valid = $urandom_range(0, 9) == 0; kill_wen = $urandom_range(0, 1) == 1; kill_rd = rreg();
            #1;
            checks++; if (issue_ready !== m_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, issue_ready, m_ready()); end
            checks++; if (fwd_rs1 !== m_fwd(int'(rs1), need_rs1) || fwd_rs2 !== m_fwd(int'(rs2), need_rs2)) begin
                failures++; $display("FAIL rand_fwd cyc=%0d got=%b%b exp=%b%b", i, fwd_rs1, fwd_rs2, m_fwd(int'(rs1), need_rs1), m_fwd(int'(rs2), need_rs2)); end
            checks++; if (busy_mask !== m_busy()) begin failures++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", i, busy_mask, m_busy()); end
            checks++; if (sb_err !== err_m) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, sb_err, err_m); end
`ifdef YSYX_23060236_HAZARD_PERF_EN
            checks++; if (perf_stall_cycles !== cyc_m || perf_stall_events !== ev_m) begin
                failures++; $display("FAIL rand_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, perf_stall_cycles, perf_stall_events, cyc_m, ev_m); end
`endif
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_saturation();
        test_simultaneous();
        test_squash();
        test_x0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
